// File: rtl/frame_io_pkg.sv
// Shared types and constants for the destination-frame read-back path.
package frame_io_pkg;

    localparam int PIX_W      = 8;
    localparam int LANES      = 4;
    localparam int WORD_W     = PIX_W * LANES;
    localparam int CNT_W      = 3;
    localparam int DEFAULT_AW = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Byte-lane keep mask for a word holding cnt pixels, lane 0 first.
    function automatic logic [LANES-1:0] keep_from_cnt(input logic [CNT_W-1:0] cnt);
        logic [LANES-1:0] keep;
        case (cnt)
            3'd0:    keep = 4'b0000;
            3'd1:    keep = 4'b0001;
            3'd2:    keep = 4'b0011;
            3'd3:    keep = 4'b0111;
            3'd4:    keep = 4'b1111;
            default: keep = 4'b0000;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/pix_packer.sv
// Four-lane byte packer: returned pixels fill lanes in order; a flush hands
// the current word out and restarts at lane 0 (or lane 1 when a byte lands
// in the same cycle). Lanes above the fill count always read as zero.
module pix_packer
    import frame_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              byte_vld_i,
    input  logic [PIX_W-1:0]  byte_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [WORD_W-1:0] word_o,
    output logic [LANES-1:0]  keep_o
);

    logic [WORD_W-1:0] lanes_q, lanes_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next lane contents and fill count from flush and returning byte.
    always_comb begin
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        if (clr_i || flush_i) begin
            lanes_d = '0;
            cnt_d   = '0;
        end else begin
            lanes_d = lanes_q;
            cnt_d   = cnt_q;
        end
        if (byte_vld_i && !clr_i) begin
            case (cnt_d)
                3'd0: begin lanes_d[0*PIX_W +: PIX_W] = byte_i; cnt_d = 3'd1; end
                3'd1: begin lanes_d[1*PIX_W +: PIX_W] = byte_i; cnt_d = 3'd2; end
                3'd2: begin lanes_d[2*PIX_W +: PIX_W] = byte_i; cnt_d = 3'd3; end
                3'd3: begin lanes_d[3*PIX_W +: PIX_W] = byte_i; cnt_d = 3'd4; end
                default: begin lanes_d = lanes_d; cnt_d = cnt_d; end
            endcase
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Lane and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
            cnt_q   <= '0;
        end else begin
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign word_o = lanes_q;
    assign keep_o = keep_from_cnt(cnt_q);

endmodule

// File: rtl/out_frame_reader.sv
// Destination-frame read-back: walks out_w*out_h pixels through a 1-cycle
// BRAM read port, packs them four per word and streams them out with
// valid/ready, while keeping a byte checksum and read/beat counters.
module out_frame_reader
    import frame_io_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [15:0]       i_out_w,
    input  logic [15:0]       i_out_h,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [WORD_W-1:0] m_tdata,
    output logic [LANES-1:0]  m_tkeep,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [31:0]       o_checksum,
    output logic [31:0]       o_mem_rd_count,
    output logic [31:0]       o_beat_count
);

    state_e            state_q;
    logic [31:0]       total_q;
    logic [31:0]       rd_idx_q;
    logic [31:0]       ret_cnt_q;
    logic              inflight_q;
    logic              busy_q;
    logic              done_q;
    logic [WORD_W-1:0] tdata_q;
    logic [LANES-1:0]  tkeep_q;
    logic              tlast_q;
    logic              tvalid_q;
    logic [31:0]       checksum_q;
    logic [31:0]       rd_cnt_q;
    logic [31:0]       beat_cnt_q;

    logic [31:0]       total_s;
    logic              start_acc_s;
    logic              hs_s;
    logic              out_free_s;
    logic              all_ret_s;
    logic              complete_s;
    logic              xfer_s;
    logic [3:0]        occ_s;
    logic              lane_ok_s;
    logic              rd_en_s;
    logic [CNT_W-1:0]  pack_cnt_s;
    logic [WORD_W-1:0] pack_word_s;
    logic [LANES-1:0]  pack_keep_s;

    assign total_s     = {16'd0, i_out_w} * {16'd0, i_out_h};
    assign start_acc_s = (state_q == IDLE) && start;
    assign hs_s        = tvalid_q && m_tready;
    assign out_free_s  = !tvalid_q || hs_s;
    assign all_ret_s   = (ret_cnt_q == total_q);
    assign occ_s       = {1'b0, pack_cnt_s} + {3'd0, inflight_q};

    // Transfer and read-issue decisions for the current cycle.
    always_comb begin
        complete_s = (pack_cnt_s == 3'd4) || (all_ret_s && (pack_cnt_s != 3'd0));
        if ((state_q == RUN) || (state_q == DRAIN)) begin
            xfer_s = complete_s && out_free_s;
        end else begin
            xfer_s = 1'b0;
        end
        // A new read needs a lane when its byte lands next cycle. With the
        // packer about to be full, that lane exists if the output register
        // will be free next cycle, since the full word then leaves exactly
        // as the byte arrives. This keeps reads gapless at one word per
        // four cycles while never dropping a byte under backpressure.
        lane_ok_s = (occ_s < 4'd4) || xfer_s || ((occ_s == 4'd4) && out_free_s);
        if (state_q == RUN) begin
            rd_en_s = (rd_idx_q < total_q) && lane_ok_s;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    pix_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (start_acc_s),
        .byte_vld_i (inflight_q),
        .byte_i     (rd_data),
        .flush_i    (xfer_s),
        .cnt_o      (pack_cnt_s),
        .word_o     (pack_word_s),
        .keep_o     (pack_keep_s)
    );

    // Frame sequencing with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            total_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        total_q <= total_s;
                        if (total_s == 32'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rd_en_s && ((rd_idx_q + 32'd1) == total_q)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs_s && tlast_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read pointer, return tracking, counters and the output word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx_q   <= '0;
            ret_cnt_q  <= '0;
            inflight_q <= 1'b0;
            checksum_q <= '0;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
        end else if (start_acc_s) begin
            rd_idx_q   <= '0;
            ret_cnt_q  <= '0;
            inflight_q <= 1'b0;
            checksum_q <= '0;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            tvalid_q   <= 1'b0;
        end else begin
            inflight_q <= rd_en_s;
            if (rd_en_s) begin
                rd_idx_q <= rd_idx_q + 32'd1;
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (inflight_q) begin
                ret_cnt_q  <= ret_cnt_q + 32'd1;
                checksum_q <= checksum_q + {24'd0, rd_data};
            end
            if (hs_s) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
            if (xfer_s) begin
                tdata_q  <= pack_word_s;
                tkeep_q  <= pack_keep_s;
                tlast_q  <= all_ret_s;
                tvalid_q <= 1'b1;
            end else if (hs_s) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign rd_en          = rd_en_s;
    assign rd_addr        = rd_idx_q[AW-1:0];
    assign m_tdata        = tdata_q;
    assign m_tkeep        = tkeep_q;
    assign m_tlast        = tlast_q;
    assign m_tvalid       = tvalid_q;
    assign o_checksum     = checksum_q;
    assign o_mem_rd_count = rd_cnt_q;
    assign o_beat_count   = beat_cnt_q;

endmodule

// File: tb/tb_out_frame_reader.sv
// Scoreboard bench for out_frame_reader: expected words are queued when a
// frame is launched and a negedge monitor pops them on every handshake.
module tb_out_frame_reader;

    localparam int AW = 19;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] i_out_w;
    logic [15:0] i_out_h;
    logic        rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]  rd_data;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] o_checksum;
    logic [31:0] o_mem_rd_count;
    logic [31:0] o_beat_count;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    word_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cur_mode = 0;

    out_frame_reader #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .i_out_w(i_out_w), .i_out_h(i_out_h),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .o_checksum(o_checksum), .o_mem_rd_count(o_mem_rd_count),
        .o_beat_count(o_beat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int mode, input int a);
        if (mode == 0) return 8'(a + 1);
        return 8'(a * 37 + 5);
    endfunction

    // Synchronous single-read BRAM model with one cycle of latency.
    initial begin
        rd_data = 8'd0;
        forever begin
            @(posedge clk);
            if (rd_en) rd_data <= pix(cur_mode, int'(rd_addr));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        word_t       e;
        bit          prev_stall = 1'b0;
        logic [31:0] pd;
        logic [3:0]  pk;
        logic        pl;
        pd = 32'd0; pk = 4'd0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
                    chk("stall_data", m_tdata, pd);
                    chk("stall_keep_last", {27'd0, m_tkeep, m_tlast}, {27'd0, pk, pl});
                end
                if (m_tvalid && m_tready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got 0x%08h expected no beat", m_tdata);
                    end else begin
                        e = sb_q.pop_front();
                        chk("beat_data", m_tdata, e.d);
                        chk("beat_keep", {28'd0, m_tkeep}, {28'd0, e.k});
                        chk("beat_last", {31'd0, m_tlast}, {31'd0, e.l});
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                pd = m_tdata; pk = m_tkeep; pl = m_tlast;
            end
        end
    end

    // Queue the expected words of a frame and return its byte sum.
    task automatic push_frame(input int n, input int mode, output logic [31:0] sum);
        word_t w;
        sum = 32'd0;
        for (int b = 0; b < n; b += 4) begin
            w.d = 32'd0;
            w.k = 4'd0;
            for (int j = 0; j < 4; j++) begin
                if (b + j < n) begin
                    w.d[8*j +: 8] = pix(mode, b + j);
                    w.k[j] = 1'b1;
                    sum = sum + {24'd0, pix(mode, b + j)};
                end
            end
            w.l = (b + 4 >= n);
            sb_q.push_back(w);
        end
    endtask

    // Launch one frame, wait (bounded) for done, then check results.
    // rmode: 0 = ready always high, 1 = ready pattern 1-0-0.
    task automatic run_frame(input int w, input int h, input int mode, input int rmode,
                             input int exp_done_k, input bit inject_start,
                             input logic [31:0] exp_sum_const, input bit use_const);
        int          n;
        int          done_k;
        bit          saw_rd;
        bit          saw_v;
        logic [31:0] sum;
        n = w * h;
        cur_mode = mode;
        push_frame(n, mode, sum);
        @(posedge clk); #1;
        i_out_w = 16'(w);
        i_out_h = 16'(h);
        m_tready = 1'b1;
        start = 1'b1;
        done_k = -1;
        saw_rd = 1'b0;
        saw_v = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (inject_start && k == 5) begin
                start = 1'b1;
                i_out_w = 16'd7;
            end
            m_tready = (rmode == 0) ? 1'b1 : ((k % 3) == 0);
            if (k == 0 && n != 0) chk("busy_after_start", {31'd0, busy}, 32'd1);
            if (rd_en) saw_rd = 1'b1;
            if (m_tvalid) saw_v = 1'b1;
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
        if (done_k < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 3000 cycles");
        end else begin
            if (exp_done_k >= 0) chk("done_edge", 32'(done_k), 32'(exp_done_k));
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            chk("checksum", o_checksum, sum);
            if (use_const) chk("checksum_const", o_checksum, exp_sum_const);
            chk("mem_rd_count", o_mem_rd_count, 32'(n));
            chk("beat_count", o_beat_count, 32'((n + 3) / 4));
            chk("queue_drained", 32'(sb_q.size()), 32'd0);
            if (n == 0) begin
                chk("zero_no_rd", {31'd0, saw_rd}, 32'd0);
                chk("zero_no_valid", {31'd0, saw_v}, 32'd0);
            end
            @(posedge clk); #1;
            chk("done_pulse_end", {31'd0, done}, 32'd0);
            chk("checksum_hold", o_checksum, sum);
        end
        sb_q.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, m_tvalid}, 32'd0);
        chk({tag, "_data"}, m_tdata, 32'd0);
        chk({tag, "_keep_last"}, {27'd0, m_tkeep, m_tlast}, 32'd0);
        chk({tag, "_rd"}, {12'd0, rd_en, rd_addr}, 32'd0);
        chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_sum"}, o_checksum, 32'd0);
        chk({tag, "_counts"}, o_mem_rd_count | o_beat_count, 32'd0);
    endtask

    initial begin
        int wk;
        rst_n = 1'b0;
        start = 1'b0;
        m_tready = 1'b0;
        i_out_w = 16'd0;
        i_out_h = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // 4x2 ramp 0x01..0x08: two full beats, checksum 36, done after E11.
        run_frame(4, 2, 0, 0, 11, 1'b0, 32'd36, 1'b1);
        // 3x3: last beat is 0x00000009 with keep 0x1.
        run_frame(3, 3, 0, 0, -1, 1'b0, 32'd45, 1'b1);
        // 16x16 with ready toggling 1-0-0.
        run_frame(16, 16, 1, 1, -1, 1'b0, 32'd0, 1'b0);
        // Empty frames: done right after the start edge.
        run_frame(0, 5, 0, 0, 0, 1'b0, 32'd0, 1'b1);
        run_frame(5, 0, 0, 0, 0, 1'b0, 32'd0, 1'b1);
        // Start pulsed while busy must be ignored.
        run_frame(3, 3, 0, 0, -1, 1'b1, 32'd45, 1'b1);

        // Reset mid-frame while a word is held under backpressure.
        cur_mode = 0;
        @(posedge clk); #1;
        i_out_w = 16'd4;
        i_out_h = 16'd2;
        m_tready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wk = 0;
        while (!m_tvalid && wk < 50) begin
            @(posedge clk); #1;
            wk++;
        end
        chk("abort_valid_seen", {31'd0, m_tvalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(4, 2, 0, 0, 11, 1'b0, 32'd36, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
